// File: rtl/mxbiu_pkg.sv
// mxbiu_pkg: shared state encoding and constants for the mxbiu bus interface unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Optional feature macro used by the bundle: MXBIU_TIMEOUT_EN.
package mxbiu_pkg;

  // One transaction at a time: idle, waiting on a read or write ack, then a
  // single completion cycle that carries the valid pulse.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    DONE    = 2'd3
  } mxbiu_state_t;

  // Read data returned for a load that timed out; sliced to DATA_WIDTH at use.
  localparam logic [63:0] MXBIU_RDATA_ERR = '1;

endpackage

// File: rtl/mxbiu_wdog.sv
// mxbiu_wdog: watchdog cycle counter for an outstanding memory transaction.
// Latency: expire is combinational from the count, asserted in the LIMIT-th waiting cycle.
// Backpressure: none; clr restarts the count, en advances it.
// Ports: clk, rst_n, clr (restart at 0), en (count this cycle), expire (limit reached now).
// Only compiled when MXBIU_TIMEOUT_EN is defined.
`ifdef MXBIU_TIMEOUT_EN
module mxbiu_wdog #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // The count holds the number of waiting cycles already completed, so the
  // LIMIT-th waiting cycle is the one where it equals LIMIT-1.
  assign expire = en && (cnt_q == CW'(LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`endif

// File: rtl/mxbiu.sv
// mxbiu: LSU-to-memory bus interface unit, one single-beat transaction outstanding.
// Latency: mem_req from the accept edge; valid pulse the cycle after mem_ack is sampled (>=2 cycles).
// Backpressure: both readies drop from acceptance until the unit returns to IDLE.
// Ports: biu_* load/store request channel from the LSU; mem_* single-beat memory port.
// Optional: MXBIU_TIMEOUT_EN adds the watchdog and the biu_err output.
module mxbiu
  import mxbiu_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] biu_rd_addr,
  output logic [DATA_WIDTH-1:0] biu_rdata,
  output logic                  biu_load_ready,
  input  logic                  biu_load,
  output logic                  biu_load_valid,
  input  logic [ADDR_WIDTH-1:0] biu_wr_addr,
  input  logic [DATA_WIDTH-1:0] biu_wdata,
  output logic                  biu_store_ready,
  input  logic                  biu_store,
  output logic                  biu_store_valid,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  input  logic                  mem_ack
`ifdef MXBIU_TIMEOUT_EN
  ,
  output logic                  biu_err
`endif
);

  mxbiu_state_t          state_q,       state_d;
  logic                  rdy_q,         rdy_d;
  logic                  load_valid_q,  load_valid_d;
  logic                  store_valid_q, store_valid_d;
  logic                  err_q,         err_d;
  logic                  mem_req_q,     mem_req_d;
  logic                  mem_we_q,      mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q,    mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q,   mem_wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q,       rdata_d;

  logic accept;
  logic waiting;
  logic timeout;

  assign accept  = (state_q == IDLE) && (biu_store || biu_load);
  assign waiting = (state_q == RD_WAIT) || (state_q == WR_WAIT);

`ifdef MXBIU_TIMEOUT_EN
  // Counter restarts on every acceptance and only runs while a waiting
  // cycle passes without an acknowledge.
  mxbiu_wdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (accept),
    .en     (waiting && !mem_ack),
    .expire (timeout)
  );
  assign biu_err = err_q;
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    rdy_d         = rdy_q;
    load_valid_d  = 1'b0;
    store_valid_d = 1'b0;
    err_d         = 1'b0;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    rdata_d       = rdata_q;

    case (state_q)
      IDLE: begin
        // Store has priority; a concurrent load simply stays pending at the
        // LSU because the readies fall with this acceptance.
        if (biu_store) begin
          state_d     = WR_WAIT;
          rdy_d       = 1'b0;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = biu_wr_addr;
          mem_wdata_d = biu_wdata;
        end else if (biu_load) begin
          state_d    = RD_WAIT;
          rdy_d      = 1'b0;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = biu_rd_addr;
        end
      end

      RD_WAIT: begin
        if (mem_ack) begin
          state_d      = DONE;
          mem_req_d    = 1'b0;
          rdata_d      = mem_rdata;
          load_valid_d = 1'b1;
        end else if (timeout) begin
          state_d      = DONE;
          mem_req_d    = 1'b0;
          rdata_d      = MXBIU_RDATA_ERR[DATA_WIDTH-1:0];
          load_valid_d = 1'b1;
          err_d        = 1'b1;
        end
      end

      WR_WAIT: begin
        if (mem_ack) begin
          state_d       = DONE;
          mem_req_d     = 1'b0;
          store_valid_d = 1'b1;
        end else if (timeout) begin
          state_d       = DONE;
          mem_req_d     = 1'b0;
          store_valid_d = 1'b1;
          err_d         = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
        rdy_d   = 1'b1;
      end

      default: begin
        state_d   = IDLE;
        rdy_d     = 1'b1;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rdy_q         <= 1'b1;
      load_valid_q  <= 1'b0;
      store_valid_q <= 1'b0;
      err_q         <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      rdata_q       <= '0;
    end else begin
      state_q       <= state_d;
      rdy_q         <= rdy_d;
      load_valid_q  <= load_valid_d;
      store_valid_q <= store_valid_d;
      err_q         <= err_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      rdata_q       <= rdata_d;
    end
  end

  assign biu_load_ready  = rdy_q;
  assign biu_store_ready = rdy_q;
  assign biu_load_valid  = load_valid_q;
  assign biu_store_valid = store_valid_q;
  assign biu_rdata       = rdata_q;
  assign mem_req         = mem_req_q;
  assign mem_we          = mem_we_q;
  assign mem_addr        = mem_addr_q;
  assign mem_wdata       = mem_wdata_q;

endmodule
